// File: rtl/apb_rr_arbiter.sv
// Two-requester round-robin arbiter driving an APB-style SETUP/ACCESS sequence to one slave.
// Define APB_ARB_TIMEOUT_EN to abort an ACCESS phase that sees no pready within TIMEOUT cycles.
module apb_rr_arbiter #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              op0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              done0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              op1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done1,
    output logic [DATA_W-1:0] rdata1,
    output logic              err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]        r_state;
    logic              r_last;
    logic              r_gnt;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_done0;
    logic              r_done1;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic              w_elig0;
    logic              w_elig1;
    logic              w_gnt_vld;
    logic              w_gnt_id;
    logic              w_gnt_op;
    logic [ADDR_W-1:0] w_gnt_addr;
    logic [DATA_W-1:0] w_gnt_wdata;
    logic              w_timeout;
    logic              w_finish;
    logic              w_rd_capture;

`ifdef APB_ARB_TIMEOUT_EN
    localparam logic [6:0] TMO_LAST = 7'(TIMEOUT - 1);

    logic [6:0] r_tmo_cnt;

    // ACCESS wait counter: cleared while in SETUP, counts stalled ACCESS cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tmo_cnt <= 7'd0;
        end else if (r_state == ST_SETUP) begin
            r_tmo_cnt <= 7'd0;
        end else if ((r_state == ST_ACCESS) && !pready) begin
            r_tmo_cnt <= r_tmo_cnt + 7'd1;
        end else begin
            r_tmo_cnt <= r_tmo_cnt;
        end
    end

    assign w_timeout = (r_state == ST_ACCESS) && !pready && (r_tmo_cnt == TMO_LAST);
`else
    logic [6:0] w_unused_tmo;
    assign w_unused_tmo = 7'(TIMEOUT);
    assign w_timeout    = 1'b0;
`endif

    // Arbitration: a requester whose done is showing this cycle is not eligible.
    always_comb begin
        w_elig0   = req0 && !r_done0;
        w_elig1   = req1 && !r_done1;
        w_gnt_vld = w_elig0 || w_elig1;
        if (w_elig0 && w_elig1) begin
            w_gnt_id = !r_last;
        end else if (w_elig1) begin
            w_gnt_id = 1'b1;
        end else begin
            w_gnt_id = 1'b0;
        end
        if (w_gnt_id) begin
            w_gnt_op    = op1;
            w_gnt_addr  = addr1;
            w_gnt_wdata = wdata1;
        end else begin
            w_gnt_op    = op0;
            w_gnt_addr  = addr0;
            w_gnt_wdata = wdata0;
        end
    end

    assign w_finish     = (r_state == ST_ACCESS) && (pready || w_timeout);
    assign w_rd_capture = (r_state == ST_ACCESS) && pready && !r_pwrite;

    // Sequencer FSM and registered APB/completion outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_last    <= 1'b1;
            r_gnt     <= 1'b0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_done0   <= 1'b0;
            r_done1   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_vld) begin
                        r_state   <= ST_SETUP;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_pwrite  <= !w_gnt_op;
                        r_paddr   <= w_gnt_addr;
                        r_pwdata  <= w_gnt_wdata;
                        r_gnt     <= w_gnt_id;
                        r_last    <= w_gnt_id;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    r_state   <= ST_ACCESS;
                    r_penable <= 1'b1;
                end
                ST_ACCESS: begin
                    if (w_finish) begin
                        r_state   <= ST_IDLE;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_done0   <= !r_gnt;
                        r_done1   <= r_gnt;
                        r_err     <= w_timeout;
                    end else begin
                        r_state <= ST_ACCESS;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

    // Per-requester read data: loaded on read completion, cleared on a timeout abort.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else if (w_timeout) begin
            if (r_gnt) begin
                r_rdata1 <= '0;
            end else begin
                r_rdata0 <= '0;
            end
        end else if (w_rd_capture) begin
            if (r_gnt) begin
                r_rdata1 <= prdata;
            end else begin
                r_rdata0 <= prdata;
            end
        end else begin
            r_rdata0 <= r_rdata0;
            r_rdata1 <= r_rdata1;
        end
    end

    assign psel    = r_psel;
    assign penable = r_penable;
    assign pwrite  = r_pwrite;
    assign paddr   = r_paddr;
    assign pwdata  = r_pwdata;
    assign done0   = r_done0;
    assign done1   = r_done1;
    assign err     = r_err;
    assign rdata0  = r_rdata0;
    assign rdata1  = r_rdata1;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Scoreboard bench for apb_rr_arbiter: directed transfers push expected completions,
// a negedge monitor pops and compares on every done pulse.
module tb_apb_rr_arbiter;

    typedef struct packed {
        logic        id;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, op0, req1, op1;
    logic [3:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        done0, done1, err;
    logic [31:0] rdata0, rdata1;
    logic        psel, penable, pwrite;
    logic [3:0]  paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;

    logic [31:0] mem [16];
    int          wait_n  = 0;
    logic        stall   = 1'b0;
    int          acc_cnt = 0;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    apb_rr_arbiter #(.ADDR_W(4), .DATA_W(32), .TIMEOUT(100)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .op0(op0), .addr0(addr0), .wdata0(wdata0), .done0(done0), .rdata0(rdata0),
        .req1(req1), .op1(op1), .addr1(addr1), .wdata1(wdata1), .done1(done1), .rdata1(rdata1),
        .err(err), .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pready(pready), .prdata(prdata)
    );

    // Slave model: pready is offered even outside ACCESS, which the arbiter must ignore.
    assign pready = !stall && (acc_cnt >= wait_n);
    assign prdata = mem[paddr];

    always @(posedge clk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
        if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: every done pulse must match the next queued completion.
    always @(negedge clk) begin
        exp_t e;
        if (rst && (done0 || done1)) begin
            chk("done_onehot", {31'b0, done0 && done1}, 32'd0);
            chk("done_psel_low", {31'b0, psel}, 32'd0);
            if (q.size() == 0) begin
                chk("unexpected_done", {30'b0, done1, done0}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("done_id", {31'b0, done1}, {31'b0, e.id});
                chk("done_rdata", e.id ? rdata1 : rdata0, e.rdata);
                chk("done_err", {31'b0, err}, {31'b0, e.err});
            end
        end
    end

    task automatic push(input logic id, input logic [31:0] rd, input logic er);
        exp_t e;
        e.id = id; e.rdata = rd; e.err = er;
        q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Single transfer with latency and phase checks; called at a negedge.
    task automatic xfer(input logic id, input logic op, input logic [3:0] a,
                        input logic [31:0] wd, input int waits, input logic [31:0] exp_rd);
        int pen = 0;
        int setup_c = -1;
        int done_c = -1;
        wait_n = waits;
        push(id, exp_rd, 1'b0);
        if (id) begin req1 = 1'b1; op1 = op; addr1 = a; wdata1 = wd; end
        else begin req0 = 1'b1; op0 = op; addr0 = a; wdata0 = wd; end
        for (int c = 0; c < 200 && done_c < 0; c++) begin
            @(negedge clk);
            if (psel && !penable && setup_c < 0) begin
                setup_c = c;
                chk("setup_paddr", {28'b0, paddr}, {28'b0, a});
                chk("setup_pwrite", {31'b0, pwrite}, {31'b0, !op});
                if (!op) chk("setup_pwdata", pwdata, wd);
            end
            if (penable) begin
                pen++;
                chk("access_paddr", {28'b0, paddr}, {28'b0, a});
            end
            if (id ? done1 : done0) begin
                done_c = c;
                if (id) req1 = 1'b0; else req0 = 1'b0;
            end
        end
        chk("setup_latency", setup_c, 32'd0);
        chk("penable_cycles", pen, waits + 1);
        chk("done_latency", done_c, waits + 2);
    endtask

    // Waits for n completions, then drops both requests before the next edge.
    task automatic wait_dones(input int n, input int budget);
        int got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            @(negedge clk);
            if (done0 || done1) got++;
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("dones_count", got, n);
    endtask

    initial begin
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; op0 = 1'b0; op1 = 1'b0;
        addr0 = 4'h0; addr1 = 4'h0; wdata0 = 32'h0; wdata1 = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_psel", {31'b0, psel}, 32'd0);
        chk("rst_penable", {31'b0, penable}, 32'd0);
        chk("rst_pwrite", {31'b0, pwrite}, 32'd0);
        chk("rst_paddr", {28'b0, paddr}, 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        chk("rst_done", {30'b0, done1, done0}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        xfer(1'b0, 1'b0, 4'h3, 32'hDEADBEEF, 0, 32'h0000_0000);
        xfer(1'b1, 1'b1, 4'h3, 32'h0000_0000, 3, 32'hDEADBEEF);
        xfer(1'b0, 1'b1, 4'h3, 32'h0000_0000, 0, 32'hDEADBEEF);
        xfer(1'b1, 1'b0, 4'h7, 32'hCAFE_0007, 1, 32'hDEADBEEF);

        // Contention straight after reset: grant order 0,1,0,1.
        do_reset();
        wait_n = 0;
        op0 = 1'b1; addr0 = 4'h3; op1 = 1'b1; addr1 = 4'h7;
        push(1'b0, 32'hDEADBEEF, 1'b0);
        push(1'b1, 32'hCAFE_0007, 1'b0);
        push(1'b0, 32'hDEADBEEF, 1'b0);
        push(1'b1, 32'hCAFE_0007, 1'b0);
        req0 = 1'b1; req1 = 1'b1;
        wait_dones(4, 100);

        xfer(1'b0, 1'b0, 4'h9, 32'h0000_A5A5, 2, 32'hDEADBEEF);

        // Reset while requester 0 sits in ACCESS; the pointer must return to favour 0.
        stall = 1'b1; wait_n = 0;
        op0 = 1'b1; addr0 = 4'h3; req0 = 1'b1;
        for (int c = 0; c < 10 && !penable; c++) @(negedge clk);
        chk("reached_access", {31'b0, penable}, 32'd1);
        op1 = 1'b1; addr1 = 4'h9; req1 = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_psel", {31'b0, psel}, 32'd0);
        chk("midrst_penable", {31'b0, penable}, 32'd0);
        chk("midrst_done", {30'b0, done1, done0}, 32'd0);
        chk("midrst_rdata0", rdata0, 32'd0);
        rst = 1'b1; stall = 1'b0;
        push(1'b0, 32'hDEADBEEF, 1'b0);
        push(1'b1, 32'h0000_A5A5, 1'b0);
        wait_dones(2, 50);

        // Slave never ready.
        @(negedge clk);
        stall = 1'b1;
        op0 = 1'b1; addr0 = 4'h3; req0 = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
        op1 = 1'b1; addr1 = 4'h7; req1 = 1'b1;
        push(1'b0, 32'h0000_0000, 1'b1);
        push(1'b1, 32'hCAFE_0007, 1'b0);
        begin
            int tmo_c = -1;
            int got = 0;
            for (int c = 0; c < 400 && got < 2; c++) begin
                @(negedge clk);
                if (done0) begin tmo_c = c; req0 = 1'b0; stall = 1'b0; end
                if (done0 || done1) got++;
            end
            req0 = 1'b0; req1 = 1'b0;
            chk("timeout_latency", tmo_c, 32'd101);
            chk("timeout_dones", got, 32'd2);
        end
`else
        repeat (500) @(negedge clk);
        chk("stall_psel", {31'b0, psel}, 32'd1);
        chk("stall_penable", {31'b0, penable}, 32'd1);
        chk("stall_err", {31'b0, err}, 32'd0);
        do_reset();
        stall = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_rr_arbiter.md
Name: apb_rr_arbiter

Overview:
Two-requester round-robin arbiter and APB-style master sequencer in front of a single Idle/Setup/Enable memory slave (16-entry, 32-bit). Each requester presents a complete transfer: op, addr and wdata. The block grants one requester at a time, drives the SETUP and ACCESS phases, waits for pready, and returns rdata with a one-cycle done pulse. It sits between the client logic and the shared memory slave.

Parameters:
ADDR_W, 4, address width; the slave has 2**ADDR_W words.
DATA_W, 32, data width.
TIMEOUT, 100, maximum ACCESS cycles allowed without pready. Used only with the optional feature.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous, active-low reset.
req0  in  1  requester 0 transfer request; level, held until done0.
op0  in  1  requester 0 operation: 0 = write, 1 = read.
addr0  in  ADDR_W  requester 0 address.
wdata0  in  DATA_W  requester 0 write data.
done0  out  1  requester 0 completion pulse, one cycle.
rdata0  out  DATA_W  requester 0 read data; valid while done0=1.
req1, op1, addr1, wdata1, done1, rdata1  same as above, for requester 1.
err  out  1  high with the done pulse when the transfer timed out.
psel  out  1  APB select.
penable  out  1  APB enable.
pwrite  out  1  APB direction: 1 = write (the inverse of op).
paddr  out  ADDR_W  APB address.
pwdata  out  DATA_W  APB write data.
pready  in  1  slave ready.
prdata  in  DATA_W  slave read data.

Behaviour:
- Reset (rst=0 at an edge):
  - state = IDLE.
  - psel, penable, pwrite, done0, done1, err = 0.
  - paddr, pwdata, rdata0, rdata1 = 0.
  - Round-robin pointer last = 1, so requester 0 wins first.
- State machine, 2-bit register: IDLE, SETUP, ACCESS.
- IDLE:
  - Eligible requester: reqN=1 and doneN=0 in this cycle. Masking by doneN stops a just-served requester from being re-granted.
  - No eligible requester: stay in IDLE.
  - One eligible requester: grant it.
  - Both eligible: grant the one that is not equal to last.
  - On grant: latch the granted op/addr/wdata into pwrite/paddr/pwdata, set last = granted, go to SETUP.
- SETUP:
  - psel=1, penable=0 for exactly one cycle, then go to ACCESS.
- ACCESS:
  - psel=1, penable=1.
  - pready=0: stay in ACCESS.
  - pready=1: go to IDLE. On the next cycle psel=penable=0, done_granted=1 for one cycle, err=0.
  - Read: rdata_granted = prdata, captured on the same edge and held until the next completion for that requester.
  - Write: rdata_granted is unchanged.
- paddr, pwdata and pwrite are stable from SETUP through the end of ACCESS.
- Minimum latency: req sampled in IDLE at edge 0 → SETUP at 1 → ACCESS at 2. With pready=1 at edge 2, done=1 in cycle 3.
- Transfers are never back-to-back: there is at least one IDLE cycle between transfers.
- Requester rules:
  - Inputs must be held stable while reqN=1 until doneN is seen.
  - reqN still high in the cycle after doneN counts as a new request; its values are sampled at the next arbitration.
- Changes to reqN while that requester's transfer is in flight are ignored. The transfer completes.
- Reset mid-transfer: the phase is abandoned, psel/penable = 0 after that edge, no done pulse, last returns to 1.
- A pready that arrives while in IDLE or SETUP is ignored.
- At most one of done0/done1 is high in any cycle.

Optional Feature:
- Macro: APB_ARB_TIMEOUT_EN.
- Defined:
  - A 7-bit counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When the counter reaches TIMEOUT-1 and pready is still 0, the transfer aborts: go to IDLE, done_granted=1 and err=1 for one cycle, rdata_granted = 0.
  - The round-robin pointer still advances.
- Not defined: no counter; ACCESS waits indefinitely; err is tied to 0.

Test Plan:
- Single write: req0=1, op0=0, addr0=4'h3, wdata0=32'hDEADBEEF, slave pready=1 immediately → psel at cycle 1, penable at cycle 2, paddr=3, pwrite=1, done0 at cycle 3. Readback of addr 3 returns DEADBEEF.
- Read with wait states: req1=1, op1=1, addr1=3, pready delayed 3 ACCESS cycles → penable high for 4 cycles, done1 one cycle after pready, rdata1=32'hDEADBEEF, done0 never asserted.
- Contention after reset: req0 and req1 both held for 4 transfers → grant order 0,1,0,1. Each done is one cycle, with one IDLE cycle between transfers.
- Reset mid-ACCESS: rst=0 while penable=1 → psel=penable=0 next cycle, no done. After release, with both requesting, requester 0 is granted first.
- With APB_ARB_TIMEOUT_EN and TIMEOUT=100, pready tied 0 → done0=1 and err=1 after 100 ACCESS cycles, rdata0=0, then the other requester is granted.
- Without APB_ARB_TIMEOUT_EN, pready tied 0 for 500 cycles → stays in ACCESS, no done, err=0.
